pc_redirect_unit: RTL
=====================

// Module: pc_redirect_unit
// PURPOSE
//  Fetch-side consumer of the jump-target datapath: owns the program counter, issues instruction-memory reads,
//  and applies redirects (ID-stage J/JAL target, EX-stage branch / JR target) with fixed priority.
//  Feeds PC+4 back to the jump-address logic and the branch adder. Sits between the imem/cache port and IF/ID latch.
//  Redirects arriving while a fetch is outstanding are held pending and applied when that fetch completes.
// PARAMETERS
//  PC_INIT    32'h0000_0000  PC value loaded on reset
//  WORD_W     32             address/data width; all targets and PC are WORD_W bits
// PORTS
//  CLK            in   1       clock; all state updates on rising edge
//  RST            in   1       synchronous active-high reset
//  ihit           in   1       imem read completed this cycle (instruction valid on imem bus)
//  halt           in   1       HALT decoded; stop fetching
//  jump_valid     in   1       ID-stage J/JAL taken
//  jump_addr      in   WORD_W  J/JAL target ({PC4[31:28],instr[25:0],2'b00})
//  ex_valid       in   1       EX-stage redirect (taken branch or JR)
//  ex_target      in   WORD_W  EX-stage redirect target
//  imemREN        out  1       instruction read request
//  imemaddr       out  WORD_W  current PC / fetch address
//  pc4            out  WORD_W  imemaddr + 4 (to jump-addr and branch logic)
//  instr_valid    out  1       fetched instruction may be latched into IF/ID
//  flush          out  1       squash IF/ID (and ID/EX when EX redirect) this cycle
//  halted         out  1       sticky: fetch stopped
//  misalign_err   out  1       sticky: a redirect target had bits [1:0] != 0
// BEHAVIOUR
//  Reset (RST=1 at edge): pc<=PC_INIT, pend_v<=0, pend_tgt<=0, halted<=0, misalign_err<=0, state<=RUN.
//   While RST high: imemREN=0, instr_valid=0, flush=0; imemaddr=pc.
//  States: RUN (imemREN=1) -> HALTED when halt=1 at an edge (halt observed same cycle as ihit: that fetch
//   still retires). HALTED: imemREN=0, instr_valid=0, pc frozen, redirects ignored; only RST exits.
//  Redirect select (combinational): ex_valid beats jump_valid; with both high, jump dropped (wrong path).
//   redir = ex_valid | jump_valid; tgt = ex_valid ? ex_target : jump_addr; tgt[1:0] forced to 2'b00 on use,
//   misalign_err<=1 if raw tgt[1:0]!=0.
//  flush = redir (RUN only), same cycle as the request; 0-cycle latency to squash.
//  PC update on edge in RUN:
//   ihit & redir              : pc<=tgt, pend_v<=0 (in-flight fetch squashed)
//   ihit & ~redir & pend_v    : pc<=pend_tgt, pend_v<=0
//   ihit & ~redir & ~pend_v   : pc<=pc+4 (wraps modulo 2^WORD_W, no flag)
//   ~ihit & redir             : pend_v<=1; pend_tgt<=tgt if ex_valid or ~pend_v (ID jump never overwrites pending)
//   ~ihit & ~redir            : hold
//  instr_valid = RUN & ihit & ~redir & ~pend_v (stale fetch after redirect never reaches decode).
//  imemaddr holds stable while imemREN=1 & ~ihit (no address change mid-request; pending used instead).
//  pc4 = pc + 4, combinational, width WORD_W.
// STRUCTURE
//  cpu_types_pkg: word_t, fetch_state_t {RUN,HALTED}, PC_INIT default, WORD_BYTES=4.
//  One sub-module natural: redirect_arb (priority select + alignment/err), combinational; rest in top.
//  Pending-redirect register (pend_v, pend_tgt) and pc register are the only datapath state.
// TESTING
//  1 Reset, ihit=1 every cycle, no redirects -> imemaddr 0,4,8,C on successive cycles; instr_valid=1 each.
//  2 pc=0x10, jump_valid=1 jump_addr=0x0000_0400 with ihit=1 -> flush=1, instr_valid=0, next imemaddr=0x400.
//  3 pc=0x20, ihit=0, ex_valid=1 target=0x80; 3 cycles later ihit=1 -> imemaddr held 0x20, instr_valid=0,
//    next imemaddr=0x80.
//  4 Same cycle jump_valid(0x400) and ex_valid(0x200), ihit=1 -> next imemaddr=0x200; pending jump then
//    ex_valid(0x300) during ihit=0 -> pending becomes 0x300 (EX overwrites; later ID jump 0x500 does not).
//  5 halt=1 with ihit=1 at pc=0x40 -> that instr_valid=1, next cycle imemREN=0, halted=1, pc stays 0x44; RST clears.
//  6 ex_target=0x103 -> pc<=0x100, misalign_err=1 sticky; pc=0xFFFF_FFFC + ihit -> wraps to 0; RST mid-wait clears pending.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared fetch-side types and constants for the PC redirect unit.
package pc_redirect_unit_pkg;
    localparam int DEF_WORD_W = 32;
    localparam int WORD_BYTES = 4;
    typedef logic [DEF_WORD_W-1:0] word_t;
    typedef enum logic {RUN, HALTED} fetch_state_t;
    localparam word_t PC_INIT_DEF = 32'h0000_0000;
endpackage

// File: rtl/pc_redirect_unit_arb.sv
// pc_redirect_unit_arb: picks the EX redirect over the ID jump, word-aligns the target and flags misalignment.
module pc_redirect_unit_arb #(
    parameter int W = 32
) (
    input  logic         i_jump_valid,
    input  logic [W-1:0] i_jump_addr,
    input  logic         i_ex_valid,
    input  logic [W-1:0] i_ex_target,
    output logic         o_redir,
    output logic [W-1:0] o_tgt,
    output logic         o_misalign
);
    logic [W-1:0] w_raw;
    assign w_raw      = i_ex_valid ? i_ex_target : i_jump_addr;
    assign o_redir    = i_ex_valid | i_jump_valid;
    assign o_tgt      = {w_raw[W-1:2], 2'b00};
    assign o_misalign = o_redir & (w_raw[1:0] != 2'b00);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the PC, issues imem reads and applies EX/ID redirects,
// parking redirects that arrive mid-fetch until that fetch completes.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int               WORD_W  = DEF_WORD_W,
    parameter logic [WORD_W-1:0] PC_INIT = PC_INIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ihit,
    input  logic              i_halt,
    input  logic              i_jump_valid,
    input  logic [WORD_W-1:0] i_jump_addr,
    input  logic              i_ex_valid,
    input  logic [WORD_W-1:0] i_ex_target,
    output logic              o_imem_ren,
    output logic [WORD_W-1:0] o_imemaddr,
    output logic [WORD_W-1:0] o_pc4,
    output logic              o_instr_valid,
    output logic              o_flush,
    output logic              o_halted,
    output logic              o_misalign_err
);
    fetch_state_t      r_state, w_state_nx;
    logic [WORD_W-1:0] r_pc, w_pc_nx, r_pend_tgt, w_pend_tgt_nx, w_tgt, w_pc4;
    logic              r_pend_v, w_pend_v_nx, r_misalign, w_misalign_nx;
    logic              w_redir, w_mis, w_run;

    pc_redirect_unit_arb #(.W(WORD_W)) u_arb (
        .i_jump_valid(i_jump_valid),
        .i_jump_addr (i_jump_addr),
        .i_ex_valid  (i_ex_valid),
        .i_ex_target (i_ex_target),
        .o_redir     (w_redir),
        .o_tgt       (w_tgt),
        .o_misalign  (w_mis)
    );

    assign w_run          = (r_state == RUN) & ~i_rst;
    assign w_pc4          = r_pc + WORD_W'(WORD_BYTES);
    assign o_imem_ren     = w_run;
    assign o_imemaddr     = r_pc;
    assign o_pc4          = w_pc4;
    assign o_flush        = w_run & w_redir;
    assign o_instr_valid  = w_run & i_ihit & ~w_redir & ~r_pend_v;
    assign o_halted       = r_state == HALTED;
    assign o_misalign_err = r_misalign;

    // The address never moves while a fetch is outstanding; redirects park in the pending slot.
    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_pend_v_nx   = r_pend_v;
        w_pend_tgt_nx = r_pend_tgt;
        w_misalign_nx = r_misalign;
        if (r_state == RUN) begin
            w_state_nx    = i_halt ? HALTED : RUN;
            w_misalign_nx = r_misalign | w_mis;
            if (i_ihit) begin
                w_pc_nx     = w_redir ? w_tgt : (r_pend_v ? r_pend_tgt : w_pc4);
                w_pend_v_nx = 1'b0;
            end else if (w_redir) begin
                w_pend_v_nx   = 1'b1;
                w_pend_tgt_nx = (i_ex_valid | ~r_pend_v) ? w_tgt : r_pend_tgt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_pc       <= PC_INIT;
            r_pend_v   <= 1'b0;
            r_pend_tgt <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_pend_v   <= w_pend_v_nx;
            r_pend_tgt <= w_pend_tgt_nx;
            r_misalign <= w_misalign_nx;
        end
    end
endmodule
